// File: rtl/dcache_pkg.sv
// Shared types and geometry for the write-back data cache.
package dcache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StSwapOut,
        StSwapIn,
        StSwapInOk
    } dcache_state_e;

    localparam int unsigned DefLineAddrLen = 3;
    localparam int unsigned DefSetAddrLen  = 4;
    localparam int unsigned LINE_WORDS     = 1 << DefLineAddrLen;
    localparam int unsigned SET_NUM        = 1 << DefSetAddrLen;

    // Byte-offset bits below the word index.
    localparam int unsigned WordLsb = 2;

    function automatic int unsigned tag_addr_len(input int unsigned line_len,
                                                 input int unsigned set_len);
        return 32 - WordLsb - line_len - set_len;
    endfunction

endpackage

// File: rtl/dcache_wb_if.sv
// Word-serial memory bus between the data cache (master) and main memory (slave).
interface dcache_wb_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_gnt;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_gnt
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_gnt
    );

endinterface

// File: rtl/dcache_line_ram.sv
// Cache data array: one combinational read port, one synchronous write port, indexed {set, word}.
module dcache_line_ram
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = DefLineAddrLen,
    parameter int unsigned SET_ADDR_LEN  = DefSetAddrLen
) (
    input  logic                     clk,
    input  logic [SET_ADDR_LEN-1:0]  rd_set,
    input  logic [LINE_ADDR_LEN-1:0] rd_word,
    output logic [31:0]              rd_data,
    input  logic                     we,
    input  logic [SET_ADDR_LEN-1:0]  wr_set,
    input  logic [LINE_ADDR_LEN-1:0] wr_word,
    input  logic [31:0]              wr_data
);

    localparam int unsigned Depth = 1 << (LINE_ADDR_LEN + SET_ADDR_LEN);

    logic [31:0] data_q [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            data_q[{wr_set, wr_word}] <= wr_data;
        end
    end

    assign rd_data = data_q[{rd_set, rd_word}];

endmodule

// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache with word-serial refill/evict bursts.
// Define DCACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module dcache_wb
    import dcache_pkg::*;
#(
    parameter int unsigned LINE_ADDR_LEN = DefLineAddrLen,
    parameter int unsigned SET_ADDR_LEN  = DefSetAddrLen
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        miss,
    dcache_wb_if.master mem
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int unsigned TAG_ADDR_LEN = tag_addr_len(LINE_ADDR_LEN, SET_ADDR_LEN);
    localparam int unsigned SetNum       = 1 << SET_ADDR_LEN;
    localparam int unsigned SetLsb       = WordLsb + LINE_ADDR_LEN;

    typedef logic [TAG_ADDR_LEN-1:0]  tag_t;
    typedef logic [SET_ADDR_LEN-1:0]  set_t;
    typedef logic [LINE_ADDR_LEN-1:0] word_t;

    localparam word_t LastBeat = {LINE_ADDR_LEN{1'b1}};

    dcache_state_e state_q, state_d;
    word_t         beat_q, beat_d;
    tag_t          lat_tag_q, lat_tag_d;
    set_t          lat_set_q, lat_set_d;
    logic [SetNum-1:0] valid_q, dirty_q;
    tag_t          tag_arr_q [SetNum];

    tag_t  req_tag;
    set_t  req_set;
    word_t req_word;
    logic  any_req, tag_match, hit, victim_dirty, miss_start;
    logic  unused_addr;

    assign req_tag     = addr[31 -: TAG_ADDR_LEN];
    assign req_set     = addr[SetLsb +: SET_ADDR_LEN];
    assign req_word    = addr[WordLsb +: LINE_ADDR_LEN];
    assign unused_addr = ^addr[WordLsb-1:0];

    assign any_req      = rd_req | wr_req;
    assign tag_match    = valid_q[req_set] && (tag_arr_q[req_set] == req_tag);
    assign hit          = (state_q == StIdle) && any_req && tag_match;
    assign miss_start   = (state_q == StIdle) && any_req && !tag_match;
    assign victim_dirty = valid_q[req_set] && dirty_q[req_set];
    assign miss         = (state_q != StIdle) || (any_req && !tag_match);

    // The read port serves the pipeline in IDLE and streams the victim during SWAP_OUT.
    set_t        ram_rd_set, ram_wr_set;
    word_t       ram_rd_word, ram_wr_word;
    logic [31:0] ram_rd_data, ram_wr_data;
    logic        ram_we;

    assign ram_rd_set  = (state_q == StSwapOut) ? lat_set_q : req_set;
    assign ram_rd_word = (state_q == StSwapOut) ? beat_q : req_word;

    dcache_line_ram #(
        .LINE_ADDR_LEN(LINE_ADDR_LEN),
        .SET_ADDR_LEN (SET_ADDR_LEN)
    ) u_line_ram (
        .clk    (clk),
        .rd_set (ram_rd_set),
        .rd_word(ram_rd_word),
        .rd_data(ram_rd_data),
        .we     (ram_we),
        .wr_set (ram_wr_set),
        .wr_word(ram_wr_word),
        .wr_data(ram_wr_data)
    );

    assign rd_data = hit ? ram_rd_data : 32'h0;

    logic        bus_req, bus_we;
    logic [31:0] bus_addr;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        lat_tag_d   = lat_tag_q;
        lat_set_d   = lat_set_q;
        bus_req     = 1'b0;
        bus_we      = 1'b0;
        bus_addr    = 32'h0;
        ram_we      = 1'b0;
        ram_wr_set  = req_set;
        ram_wr_word = req_word;
        ram_wr_data = wr_data;
        unique case (state_q)
            StIdle: begin
                if (miss_start) begin
                    state_d   = victim_dirty ? StSwapOut : StSwapIn;
                    lat_tag_d = req_tag;
                    lat_set_d = req_set;
                    beat_d    = '0;
                end else if (hit && wr_req) begin
                    ram_we = 1'b1;
                end
            end
            StSwapOut: begin
                bus_req  = 1'b1;
                bus_we   = 1'b1;
                bus_addr = {tag_arr_q[lat_set_q], lat_set_q, beat_q, 2'b00};
                if (mem.mem_gnt) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = StSwapIn;
                        beat_d  = '0;
                    end
                end
            end
            StSwapIn: begin
                bus_req  = 1'b1;
                bus_addr = {lat_tag_q, lat_set_q, beat_q, 2'b00};
                if (mem.mem_gnt) begin
                    ram_we      = 1'b1;
                    ram_wr_set  = lat_set_q;
                    ram_wr_word = beat_q;
                    ram_wr_data = mem.mem_rdata;
                    beat_d      = beat_q + 1'b1;
                    if (beat_q == LastBeat) begin
                        state_d = StSwapInOk;
                    end
                end
            end
            StSwapInOk: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign mem.mem_req   = bus_req;
    assign mem.mem_we    = bus_we;
    assign mem.mem_addr  = bus_addr;
    assign mem.mem_wdata = (state_q == StSwapOut) ? ram_rd_data : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            beat_q    <= '0;
            lat_tag_q <= '0;
            lat_set_q <= '0;
            valid_q   <= '0;
            dirty_q   <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            lat_tag_q <= lat_tag_d;
            lat_set_q <= lat_set_d;
            if (hit && wr_req) begin
                dirty_q[req_set] <= 1'b1;
            end
            if (state_q == StSwapInOk) begin
                valid_q[lat_set_q] <= 1'b1;
                dirty_q[lat_set_q] <= 1'b0;
            end
        end
    end

    // Tags are qualified by valid_q, so the array itself needs no reset.
    always_ff @(posedge clk) begin
        if (state_q == StSwapInOk) begin
            tag_arr_q[lat_set_q] <= lat_tag_q;
        end
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt_q  <= 32'h0;
            miss_cnt_q <= 32'h0;
        end else begin
            if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: doc/dcache_wb.md
Name: dcache_wb

Overview:
- Direct-mapped, write-back, write-allocate data cache between the MEM-stage load/store path and a slow word-serial main memory.
- Produces the pipeline's DCacheMiss stall request: asserted while a miss is being serviced, so the hazard logic stalls the pipeline until the access completes.
- Hits complete in the request cycle. Misses run a victim write-back burst when needed, then a refill burst.

Parameters:
- LINE_ADDR_LEN, 3, log2 of words per line (default 8 words).
- SET_ADDR_LEN, 4, log2 of number of lines (default 16 sets).
- TAG_ADDR_LEN, 32-2-LINE_ADDR_LEN-SET_ADDR_LEN, derived; not overridable.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_req  in  1  load request from MEM stage.
- wr_req  in  1  store request from MEM stage.
- addr  in  32  byte address; bits [1:0] ignored (word access only).
- wr_data  in  32  store data.
- rd_data  out  32  load data; valid when rd_req=1 and miss=0.
- miss  out  1  stall request to hazard logic (DCacheMiss).
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  32  word-aligned beat address.
- mem_wdata  out  32  write-beat data.
- mem_rdata  in  32  read-beat data; valid when mem_gnt=1.
- mem_gnt  in  1  one-cycle beat acknowledge.

Behaviour:
- Address split: tag = addr[31 -: TAG_ADDR_LEN]; set = next SET_ADDR_LEN bits; word = addr[LINE_ADDR_LEN+1:2].
- Per line: valid bit, dirty bit, tag, LINE_WORDS x 32 data.
- Hit: valid and tag match.
  - Hit read: rd_data driven combinationally in the same cycle; miss=0.
  - Hit write: word updated at clock edge and dirty set; miss=0.
- miss is combinational: (rd_req|wr_req) and not hit while IDLE, or state != IDLE.
- rd_req and wr_req both high is illegal: treated as a write, and rd_data is undefined.
- FSM states:
  - IDLE: on a missing request, go to SWAP_OUT if the victim is valid and dirty, else SWAP_IN. Latch the request address.
  - SWAP_OUT: issue LINE_WORDS write beats to {victim tag, set, beat, 2'b0}, beats 0..N-1 in order. Hold mem_req=1 and mem_we=1 until mem_gnt, then advance the beat counter. After the last gnt, go to SWAP_IN.
  - SWAP_IN: issue LINE_WORDS read beats to {new tag, set, beat, 2'b0}, writing each mem_rdata into the line on its gnt. After the last gnt, go to SWAP_IN_OK.
  - SWAP_IN_OK: write tag, set valid=1 and dirty=0, go to IDLE. The stalled request re-presents the next cycle and hits; miss drops that cycle.
- Beat counter: LINE_ADDR_LEN bits, cleared on entry to SWAP_OUT/SWAP_IN; wraps to 0 after the last beat.
- mem_req is low in IDLE and SWAP_IN_OK. mem_addr, mem_wdata and mem_we stay stable while mem_req=1 and mem_gnt=0.
- Requester contract: rd_req, wr_req, addr and wr_data are held stable while miss=1. The request is not withdrawn mid-miss.
- mem_gnt while mem_req=0 is ignored.
- Reset values: state IDLE, all valid=0, all dirty=0, counter 0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0 when no hit, miss=0.
- rst mid-burst: next cycle returns to IDLE, mem_req=0, all lines invalid. Dirty data is discarded (rst is a whole-CPU reset).
- Tag/data array contents are not reset; only valid and dirty bits are.

Optional Feature:
- Macro: DCACHE_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs hit_cnt[31:0] and miss_cnt[31:0], both cleared by rst.
  - hit_cnt increments once per IDLE-state hit cycle with a request.
  - miss_cnt increments once per IDLE to SWAP_OUT/SWAP_IN transition.
  - Both counters saturate at 32'hFFFF_FFFF.
- Without the macro: the ports and counters are absent. Functional behaviour is identical.

Decomposition:
- Package dcache_pkg:
  - FSM state enum {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK}.
  - Derived localparams LINE_WORDS and SET_NUM.
  - Address-field slice helper constants.
- Natural sub-module: dcache_line_ram. It holds the data array, with one combinational read port (word select) and one synchronous write port.
- Tag/valid/dirty arrays and the FSM stay in dcache_wb.

Test Plan:
- Cold read: after rst, rd_req at addr 0x0000_0040. Required: miss=1 immediately; 8 read beats at 0x40..0x5C; no write beats. miss=0 on the cycle after SWAP_IN_OK; rd_data equals the memory word at 0x40.
- Hit after fill: rd_req 0x44, then wr_req 0x48 data 0xDEAD_BEEF, then rd_req 0x48. Required: all three with miss=0 and no mem_req; final rd_data=0xDEAD_BEEF.
- Dirty eviction: write 0x0000_0040 with 0x1234_5678, then read conflicting 0x0000_0840 (same set, different tag). Required: 8 write beats at 0x40..0x5C, the first carrying mem_wdata=0x1234_5678; then 8 read beats at 0x840..0x85C; memory[0x40]=0x1234_5678 afterward.
- Slow memory: mem_gnt only every 3rd cycle during a refill. Required: mem_addr and mem_we held stable between grants; exactly 8 beats; miss stays 1 throughout.
- Reset mid-refill: rst pulse after 3 of 8 read grants. Required: the next cycle is IDLE with mem_req=0 and miss=0. A subsequent rd_req 0x40 misses again and does a full 8-beat refill.
- With DCACHE_PERF_CNT_EN, after the cold-read plus hit scenarios: hit_cnt=4 (the re-presented hit after the refill plus the three hits) and miss_cnt=1.
